// File: rtl/tug_referee_if.sv
// Round-result inputs and referee outputs for the tug-of-war referee.
interface tug_referee_if;
   logic       winrnd;
   logic       right;
   logic       tie;
   logic       clr;
   logic [8:0] leds;
   logic       win_l;
   logic       win_r;
   logic [7:0] rounds;

   modport master (
      output winrnd, right, tie,
      input  clr, leds, win_l, win_r, rounds
   );

   modport slave (
      input  winrnd, right, tie,
      output clr, leds, win_l, win_r, rounds
   );
endinterface

// File: rtl/tug_referee.sv
// Tug-of-war referee: moves the rope on scored rounds, re-arms the button
// latch through a timed clear phase and latches the game winner.
module tug_referee #(
   parameter int unsigned CLR_CYCLES = 4
) (
   input  logic          clk,
   input  logic          rst,
   tug_referee_if.slave  bus
);

   localparam int unsigned POS_W = 4;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned LED_W = 9;
   localparam int unsigned RND_W = 8;

   localparam logic [POS_W-1:0] POS_LEFT  = POS_W'(0);
   localparam logic [POS_W-1:0] POS_MID   = POS_W'(4);
   localparam logic [POS_W-1:0] POS_RIGHT = POS_W'(8);
   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(CLR_CYCLES);
   localparam logic [RND_W-1:0] RND_MAX   = {RND_W{1'b1}};

   typedef enum logic [1:0] {
      ARMED  = 2'd0,
      CLEAR  = 2'd1,
      OVER_L = 2'd2,
      OVER_R = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [POS_W-1:0]   pos_q, pos_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [RND_W-1:0]   rounds_q, rounds_d;
   logic [LED_W-1:0]   leds_q, leds_d;
   logic               clr_q, clr_d;
   logic               win_l_q, win_l_d;
   logic               win_r_q, win_r_d;

   // Next-state, rope position, clear counter and registered output values
   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      cnt_d    = cnt_q;
      rounds_d = rounds_q;

      unique case (state_q)
         ARMED: begin
            if (bus.winrnd) begin
               rounds_d = (rounds_q == RND_MAX) ? rounds_q : rounds_q + RND_W'(1);
               if (bus.tie) begin
                  state_d = CLEAR;
                  cnt_d   = CNT_LOAD;
               end else if (bus.right) begin
                  pos_d = pos_q + POS_W'(1);
                  if (pos_d == POS_RIGHT) begin
                     state_d = OVER_R;
                     cnt_d   = '0;
                  end else begin
                     state_d = CLEAR;
                     cnt_d   = CNT_LOAD;
                  end
               end else begin
                  pos_d = pos_q - POS_W'(1);
                  if (pos_d == POS_LEFT) begin
                     state_d = OVER_L;
                     cnt_d   = '0;
                  end else begin
                     state_d = CLEAR;
                     cnt_d   = CNT_LOAD;
                  end
               end
            end
         end
         CLEAR: begin
            // Leaving on count 1 keeps clr high for exactly CLR_CYCLES cycles
            if (cnt_q <= CNT_W'(1)) begin
               state_d = ARMED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         OVER_L: pos_d = POS_LEFT;
         OVER_R: pos_d = POS_RIGHT;
         default: state_d = ARMED;
      endcase

      clr_d   = (state_d != ARMED);
      win_l_d = (state_d == OVER_L);
      win_r_d = (state_d == OVER_R);
      leds_d  = LED_W'(1) << pos_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ARMED;
         pos_q    <= POS_MID;
         cnt_q    <= '0;
         rounds_q <= '0;
         leds_q   <= LED_W'(1) << POS_MID;
         clr_q    <= 1'b0;
         win_l_q  <= 1'b0;
         win_r_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         cnt_q    <= cnt_d;
         rounds_q <= rounds_d;
         leds_q   <= leds_d;
         clr_q    <= clr_d;
         win_l_q  <= win_l_d;
         win_r_q  <= win_r_d;
      end
   end

   assign bus.clr    = clr_q;
   assign bus.leds   = leds_q;
   assign bus.win_l  = win_l_q;
   assign bus.win_r  = win_r_q;
   assign bus.rounds = rounds_q;

endmodule

// File: doc/tug_referee.md
TUG_REFEREE -- requirements
Module: tug_referee

Interface
REQ-001 SHALL have parameter CLR_CYCLES, default 4, meaning the number of cycles clr is held after a scored round (legal range 1..15).
REQ-002 SHALL have port clk  input  1  meaning the single system clock, rising-edge active.
REQ-003 SHALL have port rst  input  1  meaning reset; one clock, reset is asynchronous and active-high.
REQ-004 SHALL have port winrnd  input  1  meaning a one-cycle round-complete pulse, synchronous to clk.
REQ-005 SHALL have port right  input  1  meaning the right player won the round; valid in the winrnd cycle.
REQ-006 SHALL have port tie  input  1  meaning both players pushed together; valid in the winrnd cycle; overrides right.
REQ-007 SHALL have port clr  output  1  meaning re-arm request to the push-button latch; active-high, registered.
REQ-008 SHALL have port leds  output  9  meaning one-hot rope position; leds[0] is the left end and leds[8] is the right end.
REQ-009 SHALL have port win_l  output  1  meaning the left player has won the game; registered.
REQ-010 SHALL have port win_r  output  1  meaning the right player has won the game; registered.
REQ-011 SHALL have port rounds  output  8  meaning the count of scored rounds, including ties.

Function
REQ-012 SHALL implement an FSM with states ARMED, CLEAR, OVER_L and OVER_R.
REQ-013 SHALL keep a 4-bit position pos in the range 0..8; leds equals 1 shifted left by pos at all times.
REQ-014 SHALL, in ARMED with winrnd=1 and tie=1, leave pos unchanged and go to CLEAR.
REQ-015 SHALL, in ARMED with winrnd=1, tie=0 and right=1, set pos to pos+1 and then go to OVER_R if the new pos is 8, else to CLEAR.
REQ-016 SHALL, in ARMED with winrnd=1, tie=0 and right=0, set pos to pos-1 and then go to OVER_L if the new pos is 0, else to CLEAR.
REQ-017 SHALL, on every winrnd accepted in ARMED, increment rounds, saturating at 255 with no wrap-around.
REQ-018 SHALL have a 1-cycle latency from the winrnd edge: the pos, leds, rounds and state updates are all visible after the same clock edge.
REQ-019 SHALL, on entry to CLEAR, load a 4-bit down-counter with CLR_CYCLES.
REQ-020 SHALL assert clr=1 throughout CLEAR and decrement the counter each cycle.
REQ-021 SHALL return to ARMED from CLEAR when the counter reaches 1, so that clr is high for exactly CLR_CYCLES cycles.
REQ-022 SHALL ignore winrnd while in CLEAR, OVER_L or OVER_R: no position move and no count.
REQ-023 SHALL, in OVER_L, hold win_l=1, win_r=0 and clr=1, and hold pos at 0.
REQ-024 SHALL, in OVER_R, hold win_r=1, win_l=0 and clr=1, and hold pos at 8.
REQ-025 SHALL leave OVER_L and OVER_R only through rst.
REQ-026 SHALL drive clr=0 in ARMED.
REQ-027 SHALL ensure win_l and win_r are never both 1.
REQ-028 SHALL never move pos outside 0..8; moves toward an end occur only from ARMED, so an out-of-range pos is unreachable.
REQ-029 SHALL ignore right and tie in any cycle where winrnd=0.
REQ-030 SHALL treat a winrnd arriving in the same cycle as the CLEAR to ARMED transition as ignored, because the FSM is still in CLEAR during that cycle.

Reset
REQ-031 SHALL, on rst=1, immediately and without waiting for clk, set state=ARMED, pos=4, leds=9'b000010000, clr=0, win_l=0, win_r=0, rounds=0 and the counter to 0.
REQ-032 SHALL let an rst asserted mid-CLEAR or in an OVER state abort that state at once, discarding the pending clr cycles.
REQ-033 SHALL hold all outputs at their reset values while rst=1.
REQ-034 SHALL accept no winrnd while rst=1.
REQ-035 SHALL process normally from the first rising clk edge after rst deasserts.

Verification
REQ-036 SHALL cover: a single right win from reset -> after the edge leds=9'b000100000 and rounds=1; clr high for exactly 4 cycles; then ARMED.
REQ-037 SHALL cover: a tie pulse -> leds unchanged at 9'b000010000, rounds=1, and clr high for 4 cycles.
REQ-038 SHALL cover: four left wins, each spaced past its CLEAR phase -> leds=9'b000000001, win_l=1, clr stuck at 1; a further winrnd changes nothing.
REQ-039 SHALL cover: a winrnd pulse issued during the 2nd cycle of CLEAR -> ignored; pos and rounds unchanged.
REQ-040 SHALL cover: rst asserted between clock edges in the middle of OVER_R -> outputs return to reset values before the next clk edge.
REQ-041 SHALL cover: 300 alternating left/right rounds -> rounds saturates at 255; pos stays in the range 3..5; win_l=win_r=0.
